mem_resp_stage: RTL and testbench
=================================

# mem_resp_stage

Parametrised memory-response stage sitting between MEM and WB in the CPU pipeline, succeeding the single-entry response-wait stage. It holds up to DEPTH in-flight instructions in order, pairs each in-order `data_ok` beat with the oldest entry still waiting for a response, and aligns and sign- or zero-extends load data. On a pipeline flush it discards all held entries and silently drops the bus responses still owed to them, so MEM can keep multiple loads and stores outstanding.

## Interface
- DEPTH, 4: max entries held; also max bus requests outstanding (live plus discarded); power of two, ≥2.
- PAYLOAD_W, 160: width of opaque sideband bundle (PC, dest, gr_we, results, exception fields) carried to WB.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM offers an instruction.
- in_ready  out  1  stage accepts; `!rst && (count + discard_cnt) < DEPTH`.
- in_payload  in  PAYLOAD_W  sideband, passed through unchanged.
- in_need_resp  in  1  a bus request was issued for this instruction (load or store); one `data_ok` is owed.
- in_mem_op  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, other = store/no load data.
- in_addr_lo  in  2  address bits [1:0] of the access.
- flush  in  1  ex_flush | ertn_flush from WB.
- data_ok  in  1  one in-order bus response beat.
- rdata  in  32  response data, valid with data_ok.
- out_valid  out  1  head entry complete and offered to WB.
- out_ready  in  1  WB accepts.
- out_payload  out  PAYLOAD_W  head sideband.
- out_data  out  32  aligned, extended load result; 0 for non-loads.
- outstanding  out  $clog2(DEPTH+1)  live entries still awaiting data_ok.
- discard_cnt  out  $clog2(DEPTH+1)  responses still to be dropped.
- resp_err  out  1  sticky: data_ok arrived with nothing owed.

## Operation
- Entry FIFO: DEPTH slots with head/tail pointers and count. Each slot holds payload, mem_op, addr_lo, need_resp, got, and data. Pointers wrap modulo DEPTH.
- Accept when in_valid && in_ready && !flush: write the slot at tail with got=0, then tail++.
- Response routing, applied in order each cycle data_ok=1:
  - If discard_cnt>0: drop the beat and decrement discard_cnt.
  - Else if an entry exists with need_resp && !got: write rdata into the oldest such entry (resp pointer) and set got=1.
  - Else: drop the beat and set resp_err=1.
- Head complete when the head is valid && (!need_resp || got || routed data_ok hits the head this cycle, the bypass case).
- out_valid = head complete && !flush.
- Pop when out_valid && out_ready: head++.
- out_data: select rdata on bypass, else the stored data.
  - Shift right by addr_lo*8.
  - lb/lbu take bits [7:0]; lh/lhu take [15:0]; lw takes all 32 bits.
  - Sign-extend for lb/lh, zero-extend for lbu/lhu; 0 for other ops.
  - Misaligned halfword/word is upstream's responsibility; extraction uses the shifted value as-is.
- Flush (has priority over accept and pop):
  - All entries are invalidated: count←0, pointers←0.
  - discard_cnt ← discard_cnt − (data_ok consumed by the discard branch this cycle) + (entries with need_resp && !got after this cycle's routing).
  - Data in entries with got=1 is lost.
- outstanding = number of live entries with need_resp && !got.
- Invariant: outstanding + discard_cnt ≤ DEPTH, enforced by in_ready.

## Timing
- Reset (asynchronous): count, pointers, discard_cnt, and resp_err are 0. Consequently out_valid=0, outstanding=0, and in_ready=0 while rst=1. Slot contents are don't-care.
- Latency for entries with need_resp=0: accepted at edge t, out_valid from cycle t+1.
- Latency for entries with need_resp=1 at the head: out_valid in the same cycle as data_ok (combinational bypass). If WB stalls, the data is captured at that edge and held.
- Full: in_ready=0 when count+discard_cnt=DEPTH. A pop and an accept in the same cycle are legal only when in_ready was already 1; in_ready does not depend on out_ready.
- Same cycle data_ok + flush: routing happens first, then conversion. A beat consumed from discard_cnt is not re-added.
- Same cycle flush + in_valid: the incoming instruction is dropped, not counted, and no discard is owed.
- Same cycle flush + out_ready: no pop, because out_valid=0.
- Reset asserted mid-operation: all state clears immediately. Bus responses already owed are not tracked; the memory side is reset together with this stage.

## Test plan
- Reset, then three ALU entries (need_resp=0) with out_ready=1 → out_valid high on cycles 1–3 after each accept, payloads in order, out_data=0.
- lb with addr_lo=3, then data_ok with rdata=0x80FF_0011 in the cycle after accept → out_valid in the same cycle, out_data=0xFFFF_FF80. lhu with addr_lo=2 on the same rdata → 0x0000_80FF.
- Four loads accepted, out_ready=0 → in_ready=0, outstanding=4. Four data_ok beats (0x1,0x2,0x3,0x4), then out_ready=1 → out_data 1,2,3,4 on consecutive cycles.
- Three loads accepted, one data_ok arrives, then flush → discard_cnt=2, in_ready true only while count+discard_cnt<4. A new load is accepted, then three data_ok (0xA,0xB,0xC) → first two dropped, new load receives 0xC.
- data_ok and flush in the same cycle with two owed loads → the beat goes to the oldest load, discard_cnt=1, out_valid=0 that cycle.
- data_ok with an empty stage and discard_cnt=0 → resp_err=1 and stays 1 until rst; no entry changes.

Source files
------------

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: in-order MEM->WB response stage holding up to DEPTH
// instructions, pairing in-order data_ok beats with the oldest waiting entry,
// aligning/extending load data and draining responses owed to flushed entries.
module mem_resp_stage #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = 160
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic                         in_need_resp,
  input  logic [2:0]                   in_mem_op,
  input  logic [1:0]                   in_addr_lo,
  input  logic                         flush,
  input  logic                         data_ok,
  input  logic [31:0]                  rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [31:0]                  out_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [$clog2(DEPTH+1)-1:0]   discard_cnt,
  output logic                         resp_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  // Slot storage (contents are don't-care while a slot is not live)
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [2:0]           r_op      [DEPTH];
  logic [1:0]           r_alo     [DEPTH];
  logic [31:0]          r_data    [DEPTH];
  logic [DEPTH-1:0]     r_need;
  logic [DEPTH-1:0]     r_got;

  // Queue control
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_discard;
  logic                 r_resp_err;

  // Combinational helpers
  logic                 w_found;
  logic [PTR_W-1:0]     w_resp_idx;
  logic [CNT_W-1:0]     w_outstanding;
  logic [CNT_W-1:0]     w_occupancy;
  logic                 w_discard_hit;
  logic                 w_route;
  logic                 w_err;
  logic                 w_head_live;
  logic                 w_bypass;
  logic                 w_head_done;
  logic                 w_accept;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_still_owed;
  logic [CNT_W-1:0]     w_discard_nxt;
  logic [31:0]          w_raw;
  logic [31:0]          w_shift;

  // Scan live entries from head: oldest waiting entry and count of waiting entries
  always_comb begin
    w_found       = 1'b0;
    w_resp_idx    = '0;
    w_outstanding = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          r_need[r_head + PTR_W'(i)] && !r_got[r_head + PTR_W'(i)]) begin
        w_outstanding = w_outstanding + CNT_W'(1);
        if (!w_found) begin
          w_found    = 1'b1;
          w_resp_idx = r_head + PTR_W'(i);
        end
      end
    end
  end

  // Response routing, handshakes and next discard count
  always_comb begin
    w_occupancy   = r_count + r_discard;
    in_ready      = !rst && (w_occupancy < CNT_W'(DEPTH));

    w_discard_hit = data_ok && (r_discard != '0);
    w_route       = data_ok && !w_discard_hit && w_found;
    w_err         = data_ok && !w_discard_hit && !w_found;

    w_head_live   = (r_count != '0);
    w_bypass      = w_route && w_head_live && (w_resp_idx == r_head);
    w_head_done   = w_head_live && (!r_need[r_head] || r_got[r_head] || w_bypass);

    out_valid     = w_head_done && !flush;
    w_pop         = out_valid && out_ready;
    w_accept      = in_valid && in_ready && !flush;

    // Entries still waiting after this cycle's routing become owed discards on flush
    w_still_owed  = w_outstanding - CNT_W'(w_route);
    w_discard_nxt = r_discard - CNT_W'(w_discard_hit);
    if (flush) begin
      w_discard_nxt = w_discard_nxt + w_still_owed;
    end
  end

  // Load data alignment and sign/zero extension for the head entry
  always_comb begin
    w_raw       = w_bypass ? rdata : r_data[r_head];
    w_shift     = w_raw >> {r_alo[r_head], 3'b000};
    out_payload = r_payload[r_head];
    unique case (r_op[r_head])
      OP_LB:   out_data = {{24{w_shift[7]}}, w_shift[7:0]};
      OP_LH:   out_data = {{16{w_shift[15]}}, w_shift[15:0]};
      OP_LW:   out_data = w_shift;
      OP_LBU:  out_data = {24'h00_0000, w_shift[7:0]};
      OP_LHU:  out_data = {16'h0000, w_shift[15:0]};
      default: out_data = 32'h0000_0000;
    endcase
  end

  // Status outputs
  always_comb begin
    outstanding = w_outstanding;
    discard_cnt = r_discard;
    resp_err    = r_resp_err;
  end

  // Queue pointers, count, discard counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_discard  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_discard <= w_discard_nxt;
      if (w_err) begin
        r_resp_err <= 1'b1;
      end
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_accept) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
      end
    end
  end

  // Slot writes: new entry at tail, response data into the routed entry
  always_ff @(posedge clk) begin
    if (w_route) begin
      r_got[w_resp_idx]  <= 1'b1;
      r_data[w_resp_idx] <= rdata;
    end
    if (w_accept) begin
      r_payload[r_tail] <= in_payload;
      r_op[r_tail]      <= in_mem_op;
      r_alo[r_tail]     <= in_addr_lo;
      r_need[r_tail]    <= in_need_resp;
      r_got[r_tail]     <= 1'b0;
      r_data[r_tail]    <= 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage with a queue-based reference model.
module tb_mem_resp_stage;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PAYLOAD_W = 160;
  localparam int unsigned CNT_W     = $clog2(DEPTH+1);

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 in_need_resp;
  logic [2:0]           in_mem_op;
  logic [1:0]           in_addr_lo;
  logic                 flush;
  logic                 data_ok;
  logic [31:0]          rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [31:0]          out_data;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     discard_cnt;
  logic                 resp_err;

  mem_resp_stage #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_need_resp(in_need_resp), .in_mem_op(in_mem_op), .in_addr_lo(in_addr_lo),
    .flush(flush), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_data(out_data), .outstanding(outstanding), .discard_cnt(discard_cnt),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [PAYLOAD_W-1:0] act,
                       input logic [PAYLOAD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order list of held instructions plus drop counter
  typedef struct {
    logic [PAYLOAD_W-1:0] payload;
    logic [2:0]           op;
    logic [1:0]           alo;
    bit                   need;
    bit                   got;
    logic [31:0]          data;
  } ent_t;

  ent_t mq[$];
  int   m_disc = 0;
  bit   m_err  = 0;

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] alo,
                                          input logic [31:0] d);
    int unsigned v;
    int          r;
    v = d >> (8 * alo);
    case (op)
      3'b000: begin r = int'(v % 256);   if (r >= 128)   r = r - 256;   return 32'(r); end
      3'b001: begin r = int'(v % 65536); if (r >= 32768) r = r - 65536; return 32'(r); end
      3'b010: return v;
      3'b100: return v % 256;
      3'b101: return v % 65536;
      default: return 32'h0;
    endcase
  endfunction

  // Compare DUT against the model every cycle, then advance the model past the edge
  always @(negedge clk) begin
    int   owed_idx;
    int   owed_n;
    bit   dhit, route, err, exp_ov, exp_rdy;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_disc = 0;
      m_err  = 0;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
    end else begin
      exp_rdy  = (mq.size() + m_disc) < DEPTH;
      owed_idx = -1;
      owed_n   = 0;
      foreach (mq[i]) begin
        if (mq[i].need && !mq[i].got) begin
          owed_n++;
          if (owed_idx < 0) owed_idx = i;
        end
      end
      check("mdl_in_ready", in_ready, exp_rdy);
      check("mdl_outstanding", outstanding, owed_n);
      check("mdl_discard_cnt", discard_cnt, m_disc);
      check("mdl_resp_err", resp_err, m_err);

      dhit  = data_ok && (m_disc > 0);
      route = data_ok && !dhit && (owed_idx >= 0);
      err   = data_ok && !dhit && (owed_idx < 0);
      if (dhit) m_disc--;
      if (route) begin
        e = mq[owed_idx];
        e.got  = 1;
        e.data = rdata;
        mq[owed_idx] = e;
      end
      if (err) m_err = 1;

      exp_ov = (mq.size() > 0) && (!mq[0].need || mq[0].got) && !flush;
      check("mdl_out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        check("mdl_out_payload", out_payload, mq[0].payload);
        check("mdl_out_data", out_data, extract(mq[0].op, mq[0].alo, mq[0].data));
      end

      if (flush) begin
        foreach (mq[i]) if (mq[i].need && !mq[i].got) m_disc++;
        mq.delete();
      end else begin
        if (exp_ov && out_ready) void'(mq.pop_front());
        if (in_valid && exp_rdy) begin
          e.payload = in_payload;
          e.op      = in_mem_op;
          e.alo     = in_addr_lo;
          e.need    = in_need_resp;
          e.got     = 0;
          e.data    = 32'h0;
          mq.push_back(e);
        end
      end
    end
  end

  // Advance one cycle; single-cycle pulses drop after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_ok  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic push(input int pl, input logic [2:0] op, input logic [1:0] alo,
                      input logic need);
    in_valid     = 1'b1;
    in_payload   = PAYLOAD_W'(pl);
    in_mem_op    = op;
    in_addr_lo   = alo;
    in_need_resp = need;
  endtask

  task automatic beat(input logic [31:0] d);
    data_ok = 1'b1;
    rdata   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_payload = '0; in_need_resp = 1'b0;
    in_mem_op = 3'b011; in_addr_lo = 2'b00; flush = 1'b0; data_ok = 1'b0;
    rdata = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_outstanding", outstanding, 0);
    rst = 1'b0;
    tick();

    // Three ALU entries stream through with one cycle latency
    out_ready = 1'b1;
    push(1, 3'b011, 2'd0, 1'b0); tick();
    push(2, 3'b011, 2'd0, 1'b0);
    @(negedge clk); check("alu1_valid", out_valid, 1); check("alu1_payload", out_payload, 1);
    tick();
    push(3, 3'b011, 2'd0, 1'b0);
    @(negedge clk); check("alu2_payload", out_payload, 2);
    tick();
    @(negedge clk); check("alu3_payload", out_payload, 3); check("alu3_data", out_data, 0);
    tick();
    @(negedge clk); check("alu_empty", out_valid, 0);
    tick();

    // Load alignment with bypass in the data_ok cycle
    push(4, 3'b000, 2'd3, 1'b1); tick();
    beat(32'h80FF_0011);
    @(negedge clk); check("lb_valid", out_valid, 1); check("lb_data", out_data, 32'hFFFF_FF80);
    tick();
    push(5, 3'b101, 2'd2, 1'b1); tick();
    beat(32'h80FF_0011);
    @(negedge clk); check("lhu_data", out_data, 32'h0000_80FF);
    tick();
    push(6, 3'b001, 2'd0, 1'b1); tick();
    beat(32'h1234_8001);
    @(negedge clk); check("lh_data", out_data, 32'hFFFF_8001);
    tick();

    // Fill with four loads while WB stalls, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(10 + i, 3'b010, 2'd0, 1'b1); tick();
    end
    @(negedge clk); check("full_in_ready", in_ready, 0); check("full_outstanding", outstanding, 4);
    tick();
    for (int k = 1; k <= 4; k++) begin
      beat(32'(k)); tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); check("drain_data", out_data, 32'(k)); check("drain_valid", out_valid, 1);
      tick();
    end

    // Flush with two responses still owed, then new loads behind the drops
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(20 + i, 3'b010, 2'd0, 1'b1); tick();
    end
    beat(32'h55); tick();
    flush = 1'b1;
    @(negedge clk); check("flush_out_valid", out_valid, 0);
    tick();
    @(negedge clk); check("flush_discard", discard_cnt, 2); check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    push(23, 3'b010, 2'd0, 1'b1); tick();
    push(24, 3'b010, 2'd0, 1'b1); tick();
    @(negedge clk); check("owed_full_in_ready", in_ready, 0);
    beat(32'hA); tick();
    beat(32'hB); tick();
    beat(32'hC);
    @(negedge clk); check("after_drop_payload", out_payload, 23); check("after_drop_data", out_data, 32'hC);
    tick();
    beat(32'hD);
    @(negedge clk); check("second_new_data", out_data, 32'hD);
    tick();

    // data_ok and flush together; incoming instruction in the same cycle is dropped
    out_ready = 1'b0;
    push(30, 3'b010, 2'd0, 1'b1); tick();
    push(31, 3'b010, 2'd0, 1'b1); tick();
    beat(32'h77); flush = 1'b1; push(32, 3'b010, 2'd0, 1'b1);
    @(negedge clk); check("same_cycle_out_valid", out_valid, 0);
    tick();
    @(negedge clk); check("same_cycle_discard", discard_cnt, 1); check("same_cycle_outstanding", outstanding, 0);
    beat(32'h88); tick();
    @(negedge clk); check("drained_discard", discard_cnt, 0); check("no_err_yet", resp_err, 0);
    tick();

    // Unexpected response sets a sticky error cleared only by reset
    beat(32'h99); tick();
    @(negedge clk); check("resp_err_set", resp_err, 1);
    repeat (3) tick();
    @(negedge clk); check("resp_err_sticky", resp_err, 1); check("resp_err_no_entry", out_valid, 0);
    push(40, 3'b011, 2'd0, 1'b0); tick();
    #2 rst = 1'b1;
    #1 check("async_rst_err", resp_err, 0); check("async_rst_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk); check("post_rst_in_ready", in_ready, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
